systolic_result_collector: RTL and testbench

//  Consumer end of the systolic_array result stream (valid/yumi). Accepts one full result

---
 rtl/systolic_result_collector_pkg.sv | 23 ++
 rtl/systolic_result_collector_if.sv | 14 +
 rtl/systolic_result_collector_tile_ram.sv | 30 +++
 rtl/systolic_result_collector.sv | 191 +++++++++++++++++++
 tb/tb_systolic_result_collector.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/systolic_result_collector_pkg.sv
// Shared types and helpers for the systolic result collector.
//   collector_state_e : collector FSM states
//   cycles_width_lp   : width of the tile-collection cycle counter
//   tile_addr()       : buffer address of output element (row, col)
package systolic_result_collector_pkg;

  localparam int unsigned cycles_width_lp = 16;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StDrain
  } collector_state_e;

  // The buffer holds words in arrival order. When transposing, arrival order is
  // treated as column-major, so row-major replay picks element (row, col) at col*h+row.
  function automatic int unsigned tile_addr(input int unsigned row, input int unsigned col,
                                            input int unsigned w, input int unsigned h,
                                            input bit transpose);
    return transpose ? (col * h + row) : (row * w + col);
  endfunction

endpackage

// File: rtl/systolic_result_collector_if.sv
// Valid/ready word stream between the collector and its neighbours.
//   valid : word present (driven by master)
//   data  : word (driven by master)
//   ready : word taken this cycle (driven by slave; used as yumi on the array side)
interface systolic_result_collector_if #(
  parameter int unsigned width_p = 8
) ();
  logic               valid;
  logic [width_p-1:0] data;
  logic               ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/systolic_result_collector_tile_ram.sv
// 1R1W tile buffer, depth_p x width_p, registered write, synchronous read.
//   clk_i   : clock
//   we_i    : write enable; waddr_i/wdata_i written on the clock edge
//   re_i    : read enable; rdata_o updates on the clock edge, holds otherwise
module systolic_result_collector_tile_ram #(
  parameter int unsigned width_p      = 8,
  parameter int unsigned depth_p      = 64,
  parameter int unsigned addr_width_p = 6
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [addr_width_p-1:0] waddr_i,
  input  logic [width_p-1:0]      wdata_i,
  input  logic                    re_i,
  input  logic [addr_width_p-1:0] raddr_i,
  output logic [width_p-1:0]      rdata_o
);

  logic [width_p-1:0] mem_q [depth_p];
  logic [width_p-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    // Holding rdata when not reading lets the output stage stall without re-reading.
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/systolic_result_collector.sv
// Collects one W*H result tile from the systolic array (valid/yumi), buffers it, then
// replays it to the host over a registered valid/ready port, optionally transposed.
//   clk_i, reset_i : clock, synchronous active-high reset
//   start_i        : arm collection (only in idle)
//   flush_i        : abort to idle, discard tile
//   arr_if         : array stream in (ready is yumi, combinational from valid)
//   host_if        : host stream out (registered valid/data)
//   busy_o         : not idle
//   done_o         : pulse the cycle after the last host handshake
//   cycles_o       : cycles spent collecting the last tile, saturating
module systolic_result_collector
  import systolic_result_collector_pkg::*;
#(
  parameter int unsigned width_p        = 8,
  parameter int unsigned array_width_p  = 8,
  parameter int unsigned array_height_p = 8,
  parameter bit          transpose_p    = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       start_i,
  input  logic                       flush_i,
  systolic_result_collector_if.slave  arr_if,
  systolic_result_collector_if.master host_if,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [cycles_width_lp-1:0] cycles_o
);

  localparam int unsigned N    = array_width_p * array_height_p;
  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned ColW = (array_width_p > 1) ? $clog2(array_width_p) : 1;
  localparam int unsigned RowW = (array_height_p > 1) ? $clog2(array_height_p) : 1;
  localparam logic [PtrW-1:0] PtrLast = PtrW'(N - 1);
  localparam logic [ColW-1:0] ColLast = ColW'(array_width_p - 1);

  collector_state_e state_q, state_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [RowW-1:0] rd_row_q, rd_row_d;
  logic [ColW-1:0] rd_col_q, rd_col_d;
  logic            rd_all_q, rd_all_d;     // every element has been read from the RAM
  logic            s1_valid_q, s1_valid_d; // RAM read data holds an unsent word
  logic            s1_last_q, s1_last_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic [width_p-1:0] out_data_q, out_data_d;
  logic [cycles_width_lp-1:0] cycles_q, cycles_d;
  logic            done_q, done_d;

  logic               accept, hs, out_free, move, issue;
  logic [PtrW-1:0]    raddr;
  logic [width_p-1:0] rdata;

  assign accept   = (state_q == StCollect) & arr_if.valid & ~flush_i;
  assign hs       = out_valid_q & host_if.ready;
  assign out_free = ~out_valid_q | host_if.ready;
  assign move     = s1_valid_q & out_free;
  // Read ahead only when the RAM data register is empty or being drained this cycle.
  assign issue    = (state_q == StDrain) & ~rd_all_q & (~s1_valid_q | move);
  assign raddr    = PtrW'(tile_addr(32'(rd_row_q), 32'(rd_col_q), array_width_p,
                                    array_height_p, transpose_p));

  systolic_result_collector_tile_ram #(
    .width_p      (width_p),
    .depth_p      (N),
    .addr_width_p (PtrW)
  ) u_tile_ram (
    .clk_i   (clk_i),
    .we_i    (accept),
    .waddr_i (wr_ptr_q),
    .wdata_i (arr_if.data),
    .re_i    (issue),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start_i) state_d = StCollect;
      StCollect: if (accept && (wr_ptr_q == PtrLast)) state_d = StDrain;
      StDrain:   if (hs && out_last_q) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    if (flush_i) state_d = StIdle;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_row_d    = rd_row_q;
    rd_col_d    = rd_col_q;
    rd_all_d    = rd_all_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    cycles_d    = cycles_q;
    done_d      = hs & out_last_q & ~flush_i;

    // Pointer terminal at PtrLast: the last accept moves to drain instead of wrapping.
    if (accept && (wr_ptr_q != PtrLast)) wr_ptr_d = wr_ptr_q + PtrW'(1);

    if (issue) begin
      s1_last_d = (rd_ptr_q == PtrLast);
      if (rd_ptr_q == PtrLast) begin
        rd_all_d = 1'b1;
      end else begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
        if (rd_col_q == ColLast) begin
          rd_col_d = '0;
          rd_row_d = rd_row_q + RowW'(1);
        end else begin
          rd_col_d = rd_col_q + ColW'(1);
        end
      end
    end

    if (issue)     s1_valid_d = 1'b1;
    else if (move) s1_valid_d = 1'b0;

    if (move) begin
      out_valid_d = 1'b1;
      out_data_d  = rdata;
      out_last_d  = s1_last_q;
    end else if (hs) begin
      out_valid_d = 1'b0;
    end

    if ((state_q == StIdle) && (state_d == StCollect)) begin
      cycles_d = '0;
    end else if ((state_q == StCollect) && !flush_i && (cycles_q != '1)) begin
      cycles_d = cycles_q + cycles_width_lp'(1);
    end

    // Leaving for idle (natural end or flush) clears all datapath tracking.
    if (state_d == StIdle) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      rd_row_d    = '0;
      rd_col_d    = '0;
      rd_all_d    = 1'b0;
      s1_valid_d  = 1'b0;
      s1_last_d   = 1'b0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_row_q    <= '0;
      rd_col_q    <= '0;
      rd_all_q    <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      cycles_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_row_q    <= rd_row_d;
      rd_col_q    <= rd_col_d;
      rd_all_q    <= rd_all_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      cycles_q    <= cycles_d;
      done_q      <= done_d;
    end
  end

  assign arr_if.ready  = accept;
  assign host_if.valid = out_valid_q;
  assign host_if.data  = out_data_q;
  assign busy_o        = (state_q != StIdle);
  assign done_o        = done_q;
  assign cycles_o      = cycles_q;

endmodule

// File: tb/tb_systolic_result_collector.sv
// Drives a straight and a transposing collector with identical stimulus and checks
// both against a tile-level model (queue of accepted words, index arithmetic).
module tb_systolic_result_collector;

  localparam int unsigned W  = 8;
  localparam int unsigned H  = 8;
  localparam int unsigned N  = W * H;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic reset, start, flush, valid_i, ready_i;
  logic [DW-1:0] data_i;
  logic busy0, done0, busy1, done1;
  logic [15:0] cycles0, cycles1;

  int n_vec = 0;
  int n_err = 0;
  string phase = "init";

  always #5 clk = ~clk;

  systolic_result_collector_if #(.width_p(DW)) arr0 ();
  systolic_result_collector_if #(.width_p(DW)) host0 ();
  systolic_result_collector_if #(.width_p(DW)) arr1 ();
  systolic_result_collector_if #(.width_p(DW)) host1 ();

  assign arr0.valid  = valid_i;
  assign arr0.data   = data_i;
  assign arr1.valid  = valid_i;
  assign arr1.data   = data_i;
  assign host0.ready = ready_i;
  assign host1.ready = ready_i;

  systolic_result_collector #(
    .width_p(DW), .array_width_p(W), .array_height_p(H), .transpose_p(1'b0)
  ) dut0 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .flush_i(flush),
    .arr_if(arr0), .host_if(host0), .busy_o(busy0), .done_o(done0), .cycles_o(cycles0)
  );

  systolic_result_collector #(
    .width_p(DW), .array_width_p(W), .array_height_p(H), .transpose_p(1'b1)
  ) dut1 (
    .clk_i(clk), .reset_i(reset), .start_i(start), .flush_i(flush),
    .arr_if(arr1), .host_if(host1), .busy_o(busy1), .done_o(done1), .cycles_o(cycles1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s/%s: observed %0h, expected %0h", phase, tag, obs, exp);
    end
  endtask

  // Drive after the edge, sample 4 ns later, still before the next edge.
  task automatic drive_cycle(input bit s, input bit f, input bit v, input logic [DW-1:0] d,
                             input bit r);
    @(posedge clk);
    #1;
    start = s; flush = f; valid_i = v; data_i = d; ready_i = r;
    #4;
  endtask

  // One full tile. vmode: 0 back-to-back, 1 every other cycle, 2 random.
  // base >= 0 gives words base, base+1, ...; otherwise random words.
  task automatic run_tile(input string nm, input int vmode, input bit rnd_ready,
                          input int base);
    logic [DW-1:0] tile[$];
    logic [DW-1:0] d;
    int ncyc, k, w, tk;
    bit v, r, stalled;
    phase = nm;
    drive_cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
    ncyc = 0;
    while (tile.size() < N && ncyc < 1000) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (ncyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      d = (base >= 0) ? DW'(base + tile.size()) : DW'($urandom);
      drive_cycle(1'b0, 1'b0, v, d, 1'($urandom_range(0, 1)));
      check("yumi0", 32'(arr0.ready), 32'(v));
      check("yumi1", 32'(arr1.ready), 32'(v));
      ncyc++;
      if (v) tile.push_back(d);
    end
    check("collect_bound", 32'(tile.size()), 32'(N));
    // Drain entry: two empty cycles, array back-pressured.
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b1, DW'($urandom), 1'b1);
      check("lat_valid", 32'(host0.valid), 32'(0));
      check("drain_yumi", 32'(arr0.ready), 32'(0));
      check("drain_busy", 32'(busy0), 32'(1));
    end
    k = 0; w = 0; stalled = 1'b0;
    while (k < N && w < 2000) begin
      r = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      drive_cycle(1'b0, 1'b0, 1'b1, DW'($urandom), r);
      if (w == 0) check("first_valid", 32'(host0.valid), 32'(1));
      if (!rnd_ready || stalled) check("valid0", 32'(host0.valid), 32'(1));
      check("valid1", 32'(host1.valid), 32'(host0.valid));
      check("done_mid", 32'(done0), 32'(0));
      if (host0.valid) begin
        tk = (k % W) * H + (k / W);
        check("data0", 32'(host0.data), 32'(tile[k]));
        check("data1", 32'(host1.data), 32'(tile[tk]));
        if (r) begin
          k++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
        end
      end
      w++;
    end
    check("drain_bound", 32'(k), 32'(N));
    drive_cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("done0", 32'(done0), 32'(1));
    check("done1", 32'(done1), 32'(1));
    check("busy_end", 32'(busy0), 32'(0));
    check("valid_end", 32'(host0.valid), 32'(0));
    check("cycles0", 32'(cycles0), 32'((ncyc > 65535) ? 65535 : ncyc));
    check("cycles1", 32'(cycles1), 32'((ncyc > 65535) ? 65535 : ncyc));
    drive_cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
    check("done_pulse", 32'(done0), 32'(0));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; flush = 1'b0; valid_i = 1'b0; ready_i = 1'b0; data_i = '0;
    phase = "reset";
    repeat (3) drive_cycle(1'b0, 1'b0, 1'b1, 8'hA5, 1'b1);
    check("yumi", 32'(arr0.ready), 32'(0));
    check("valid", 32'(host0.valid), 32'(0));
    check("data", 32'(host0.data), 32'(0));
    check("busy", 32'(busy0), 32'(0));
    check("done", 32'(done0), 32'(0));
    check("cycles", 32'(cycles0), 32'(0));
    reset = 1'b0;

    phase = "idle";
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b1, DW'($urandom), 1'b1);
      check("yumi", 32'(arr0.ready), 32'(0));
      check("valid", 32'(host0.valid), 32'(0));
      check("busy", 32'(busy0), 32'(0));
    end
    drive_cycle(1'b1, 1'b1, 1'b1, '0, 1'b1);
    drive_cycle(1'b0, 1'b0, 1'b1, '0, 1'b1);
    check("start_flush_busy", 32'(busy0), 32'(0));
    check("start_flush_yumi", 32'(arr0.ready), 32'(0));

    run_tile("b2b", 0, 1'b0, 1);
    run_tile("seq0", 0, 1'b0, 0);
    run_tile("toggle", 1, 1'b0, -1);
    run_tile("stall", 2, 1'b1, -1);

    phase = "flush";
    drive_cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b1, DW'($urandom), 1'b1);
      check("yumi", 32'(arr0.ready), 32'(1));
    end
    drive_cycle(1'b1, 1'b1, 1'b1, DW'($urandom), 1'b1);
    check("flush_yumi", 32'(arr0.ready), 32'(0));
    drive_cycle(1'b0, 1'b0, 1'b1, DW'($urandom), 1'b1);
    check("flush_busy", 32'(busy0), 32'(0));
    check("flush_valid", 32'(host0.valid), 32'(0));
    check("flush_yumi_idle", 32'(arr0.ready), 32'(0));
    check("flush_cycles", 32'(cycles0), 32'(30));

    run_tile("post_flush", 2, 1'b1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
